// File: rtl/adding_machine_pkg.sv
// Shared constants and state type for the adding-machine controller.
// Opcodes, the reserved HLT encoding, and the FSM state enum.
package adding_machine_pkg;

    localparam logic [1:0] OP_LDA    = 2'b00;
    localparam logic [1:0] OP_STA    = 2'b01;
    localparam logic [1:0] OP_ADDI   = 2'b10;
    localparam logic [1:0] OP_JMP    = 2'b11;
    localparam logic [7:0] INSTR_HLT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EX_RD,
        S_EX_WR,
        S_EX_ADD,
        S_EX_JMP,
        S_HALT
    } ctrl_state_t;

endpackage

// File: rtl/adding_machine_controller_if.sv
// Memory handshake bundle between the controller and program/data memory.
// master: drives mem_rd/mem_wr, samples mem_ready. slave: the memory side.
interface adding_machine_controller_if;

    logic mem_rd;
    logic mem_wr;
    logic mem_ready;

    modport master (
        output mem_rd,
        output mem_wr,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        output mem_ready
    );

endinterface

// File: rtl/adding_machine_controller.sv
// Fetch/decode/execute sequencer for the adding-machine datapath.
// Ports: clock, reset, start, ir[7:0], mem (handshake), datapath strobes,
// busy, halted, instr_count[7:0].
module adding_machine_controller
    import adding_machine_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ir,
    adding_machine_controller_if.master mem,
    output logic       load_IR,
    output logic       load_acc,
    output logic       sel_bus,
    output logic       sel_alu,
    output logic       pass_add,
    output logic       div_pass,
    output logic       ld_pc,
    output logic       clr_pc,
    output logic       inc_pc,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       busy,
    output logic       halted,
    output logic [7:0] instr_count
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [7:0]  cnt_q;
    logic        retire;
    logic        cnt_clr;
    logic        rd;
    logic        wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= 8'd0;
            end else if (retire) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        cnt_clr   = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        load_IR   = 1'b0;
        load_acc  = 1'b0;
        sel_bus   = 1'b0;
        sel_alu   = 1'b0;
        pass_add  = 1'b0;
        div_pass  = 1'b0;
        ld_pc     = 1'b0;
        clr_pc    = 1'b0;
        inc_pc    = 1'b0;
        ir_on_adr = 1'b0;
        pc_on_adr = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr_pc  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                pc_on_adr = 1'b1;
                rd        = 1'b1;
                sel_bus   = 1'b1;
                if (mem.mem_ready) begin
                    load_IR = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                // The reserved JMP 63 encoding must win over the JMP opcode.
                if (ir == INSTR_HLT) begin
                    state_d = S_HALT;
                end else begin
                    unique case (ir[7:6])
                        OP_LDA:  state_d = S_EX_RD;
                        OP_STA:  state_d = S_EX_WR;
                        OP_ADDI: state_d = S_EX_ADD;
                        OP_JMP:  state_d = S_EX_JMP;
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_EX_RD: begin
                busy      = 1'b1;
                ir_on_adr = 1'b1;
                rd        = 1'b1;
                sel_bus   = 1'b1;
                if (mem.mem_ready) begin
                    load_acc = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EX_WR: begin
                busy      = 1'b1;
                ir_on_adr = 1'b1;
                wr        = 1'b1;
                sel_alu   = 1'b1;
                div_pass  = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EX_ADD: begin
                busy     = 1'b1;
                sel_alu  = 1'b1;
                pass_add = 1'b1;
                load_acc = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EX_JMP: begin
                busy    = 1'b1;
                ld_pc   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset silences every output in the same cycle, so an in-flight
        // request is dropped rather than completed on the reset edge.
        if (reset) begin
            rd        = 1'b0;
            wr        = 1'b0;
            load_IR   = 1'b0;
            load_acc  = 1'b0;
            sel_bus   = 1'b0;
            sel_alu   = 1'b0;
            pass_add  = 1'b0;
            div_pass  = 1'b0;
            ld_pc     = 1'b0;
            clr_pc    = 1'b0;
            inc_pc    = 1'b0;
            ir_on_adr = 1'b0;
            pc_on_adr = 1'b0;
            busy      = 1'b0;
            halted    = 1'b0;
        end
    end

    assign mem.mem_rd  = rd;
    assign mem.mem_wr  = wr;
    assign instr_count = reset ? 8'd0 : cnt_q;

endmodule
